// File: rtl/memory_loader.sv
// Byte-to-word loader: packs four bytes little-endian into a word and issues
// one write strobe per word to a memory, stopping once depth words are stored.
module memory_loader #(
    parameter int memory_size = 16,
    parameter int word_size   = 32,
    parameter int depth       = 200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             byte_in,
    input  logic                   byte_valid,
    output logic                   byte_ready,
    input  logic                   clear,
    input  logic                   rwn,
    output logic [memory_size-1:0] address_dec,
    output logic [word_size-1:0]   word_out,
    output logic                   start,
    output logic [7:0]             word_count,
    output logic                   full
);

    localparam logic [1:0] COLLECT = 2'd0;
    localparam logic [1:0] WRITE   = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;
    localparam int         LANES   = word_size / 8;
    localparam logic [8:0] DEPTH_W = 9'(depth);

    logic [1:0]             state_reg, state_next;
    logic [1:0]             byte_cnt_reg, byte_cnt_next;
    logic [memory_size-1:0] addr_reg, addr_next;
    logic [7:0]             count_reg, count_next;
    logic [8:0]             count_inc;
    logic                   accept;
    logic                   commit;

    // clear dominates both byte acceptance and the memory commit
    assign accept    = (state_reg == COLLECT) && byte_valid && !clear;
    assign commit    = (state_reg == WRITE) && !rwn && !clear;
    assign count_inc = {1'b0, count_reg} + 9'd1;

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        addr_next     = addr_reg;
        count_next    = count_reg;
        if (clear) begin
            state_next    = COLLECT;
            byte_cnt_next = 2'd0;
            addr_next     = '0;
            count_next    = 8'd0;
        end else if (accept) begin
            byte_cnt_next = byte_cnt_reg + 2'd1;
            if (byte_cnt_reg == 2'd3) begin
                state_next = WRITE;
            end
        end else if (commit) begin
            addr_next  = addr_reg + memory_size'(1);
            count_next = count_inc[7:0];
            state_next = (count_inc == DEPTH_W) ? FULL : COLLECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= COLLECT;
            byte_cnt_reg <= 2'd0;
            addr_reg     <= '0;
            count_reg    <= 8'd0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            addr_reg     <= addr_next;
            count_reg    <= count_next;
        end
    end

    // One register per byte lane; a lane loads only when its slot is the next to fill.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [7:0] lane_reg;

        always_ff @(posedge clk) begin
            if (!reset) begin
                lane_reg <= 8'd0;
            end else if (accept && (int'(byte_cnt_reg) == gi)) begin
                lane_reg <= byte_in;
            end
        end

        assign word_out[gi*8 +: 8] = lane_reg;
    end

    assign address_dec = addr_reg;
    assign word_count  = count_reg;
    assign byte_ready  = (state_reg == COLLECT);
    assign start       = (state_reg == WRITE);
    assign full        = (state_reg == FULL);

endmodule

// File: tb/tb_memory_loader.sv
// Self-checking bench for memory_loader: table-driven words, hand-written
// corner sequences and a randomized run against a byte-queue reference model.
module tb_memory_loader;

    localparam int DEPTH = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        clear;
    logic        rwn;
    logic [15:0] address_dec;
    logic [31:0] word_out;
    logic        start;
    logic [7:0]  word_count;
    logic        full;

    memory_loader #(.memory_size(16), .word_size(32), .depth(DEPTH)) dut (
        .clk(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .clear(clear), .rwn(rwn),
        .address_dec(address_dec), .word_out(word_out), .start(start),
        .word_count(word_count), .full(full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: accepted bytes queue, pending assembled word, committed count.
    logic [7:0]  m_q[$];
    logic [31:0] m_word;
    bit          m_pending;
    bit          m_full;
    int          m_count;

    int          start_cycles;
    logic [31:0] seen_word;
    logic [15:0] seen_addr;

    typedef struct {
        logic [7:0]  b0, b1, b2, b3;
        int          hold;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl[4];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_word    = 32'd0;
        m_pending = 0;
        m_full    = 0;
        m_count   = 0;
    endfunction

    task automatic run_cycle(input logic v, input logic [7:0] b, input logic r, input logic c);
        byte_valid = v;
        byte_in    = b;
        rwn        = r;
        clear      = c;
        chk("byte_ready", {31'd0, byte_ready}, {31'd0, !m_pending && !m_full});
        chk("start", {31'd0, start}, {31'd0, m_pending});
        chk("full", {31'd0, full}, {31'd0, m_full});
        chk("word_count", {24'd0, word_count}, 32'(m_count & 8'hff));
        chk("address_dec", {16'd0, address_dec}, 32'(m_count & 16'hffff));
        if (m_pending) chk("word_out", word_out, m_word);
        if (start) begin
            start_cycles++;
            seen_word = word_out;
            seen_addr = address_dec;
        end
        @(posedge clk);
        #1;
        if (c) begin
            m_q.delete();
            m_pending = 0;
            m_full    = 0;
            m_count   = 0;
        end else if (m_pending) begin
            if (!r) begin
                $display("write addr=%0d data=%h", m_count, m_word);
                m_count++;
                m_pending = 0;
                if (m_count == DEPTH) m_full = 1;
            end
        end else if (!m_full && v) begin
            m_q.push_back(b);
            if (m_q.size() == 4) begin
                m_word    = {m_q[3], m_q[2], m_q[1], m_q[0]};
                m_pending = 1;
                m_q.delete();
            end
        end
    endtask

    task automatic apply_reset();
        reset      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'd0;
        clear      = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_word_out", word_out, 32'd0);
        chk("rst_address", {16'd0, address_dec}, 32'd0);
        chk("rst_count", {24'd0, word_count}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        reset = 1'b1;
        model_reset();
        $display("reset applied");
    endtask

    initial begin
        reset = 1'b0; byte_in = 8'd0; byte_valid = 1'b0; clear = 1'b0; rwn = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        tbl[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 32'h44332211};
        tbl[1] = '{8'hde, 8'had, 8'hbe, 8'hef, 3, 32'hefbeadde};
        tbl[2] = '{8'h00, 8'hff, 8'h00, 8'hff, 1, 32'hff00ff00};
        tbl[3] = '{8'h80, 8'h01, 8'h7f, 8'hfe, 0, 32'hfe7f0180};
        for (int i = 0; i < 4; i++) begin
            start_cycles = 0;
            run_cycle(1, tbl[i].b0, 1, 0);
            run_cycle(1, tbl[i].b1, 0, 0);
            run_cycle(1, tbl[i].b2, 1, 0);
            run_cycle(1, tbl[i].b3, 0, 0);
            for (int h = 0; h < tbl[i].hold; h++) run_cycle(1, 8'h55, 1, 0);
            run_cycle(1, 8'h66, 0, 0);
            chk("tbl_word", seen_word, tbl[i].exp);
            chk("tbl_addr", {16'd0, seen_addr}, 32'(i));
            chk("tbl_start_cycles", 32'(start_cycles), 32'(tbl[i].hold + 1));
            chk("tbl_count", {24'd0, word_count}, 32'(i + 1));
            $display("vector %0d word=%h start_cycles=%0d", i, seen_word, start_cycles);
        end

        // Partial word discarded by clear; byte offered alongside clear is dropped.
        run_cycle(1, 8'hA1, 0, 0);
        run_cycle(1, 8'hA2, 0, 0);
        run_cycle(1, 8'hA3, 0, 1);
        chk("clr_count", {24'd0, word_count}, 32'd0);
        start_cycles = 0;
        run_cycle(1, 8'h01, 0, 0);
        run_cycle(1, 8'h02, 0, 0);
        run_cycle(1, 8'h03, 0, 0);
        run_cycle(1, 8'h04, 0, 0);
        run_cycle(0, 8'h00, 0, 0);
        chk("clr_word", seen_word, 32'h04030201);
        chk("clr_addr", {16'd0, seen_addr}, 32'd0);
        chk("clr_start_cycles", 32'(start_cycles), 32'd1);

        // byte_valid toggling: only valid bytes are packed.
        for (int i = 0; i < 10; i++) run_cycle(i[0] == 1'b0, 8'(8'h30 + i), 0, 0);
        run_cycle(0, 8'h00, 0, 0);
        chk("toggle_word", seen_word, 32'h36343230);

        // Reset while a write is pending with rwn held high.
        run_cycle(1, 8'hC1, 1, 0);
        run_cycle(1, 8'hC2, 1, 0);
        run_cycle(1, 8'hC3, 1, 0);
        run_cycle(1, 8'hC4, 1, 0);
        run_cycle(0, 8'h00, 1, 0);
        rwn = 1'b1;
        apply_reset();
        run_cycle(0, 8'h00, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            run_cycle(($urandom_range(9) < 7), 8'($urandom), ($urandom_range(9) < 3),
                      ($urandom_range(99) == 0));
        end

        // Fill to depth, then confirm extra bytes are ignored.
        run_cycle(0, 8'h00, 0, 1);
        for (int w = 0; w < DEPTH; w++) begin
            for (int k = 0; k < 4; k++) run_cycle(1, 8'($urandom), 0, 0);
            run_cycle(1, 8'h00, 0, 0);
        end
        chk("full_last_addr", {16'd0, seen_addr}, 32'd199);
        chk("full_flag", {31'd0, full}, 32'd1);
        chk("full_ready", {31'd0, byte_ready}, 32'd0);
        chk("full_count", {24'd0, word_count}, 32'd200);
        for (int i = 0; i < 8; i++) run_cycle(1, 8'($urandom), 0, 0);
        chk("full_hold_count", {24'd0, word_count}, 32'd200);
        run_cycle(0, 8'h00, 0, 1);
        run_cycle(0, 8'h00, 0, 0);
        chk("full_cleared", {31'd0, byte_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
